// File: rtl/maze_query_arbiter_if.sv
// Bundle between the maze query arbiter and its environment: the four
// requesters (pacman + three monsters) and the shared maze-lookup unit.
//   req       : per-requester request, bit0 pacman, bits1..3 monsters 0..2
//   req_x/y   : packed 9-bit query coordinates, requester i at [9i+8:9i]
//   lk_valid  : one-cycle strobe to the lookup unit
//   lk_x/y    : coordinate presented to the lookup unit
//   lk_flags  : lookup result {L,U,R,D}, 1 = free
//   rsp_valid : one-hot completion pulse per requester
//   rsp_flags : registered lookup result
//   busy      : arbiter not idle
//   grant_id  : index of the requester being served
// modport slave is the arbiter side; master is the environment side.
interface maze_query_arbiter_if;
    logic [3:0]  req;
    logic [35:0] req_x;
    logic [35:0] req_y;
    logic        lk_valid;
    logic [8:0]  lk_x;
    logic [8:0]  lk_y;
    logic [3:0]  lk_flags;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_flags;
    logic        busy;
    logic [1:0]  grant_id;

    modport master (
        output req, req_x, req_y, lk_flags,
        input  lk_valid, lk_x, lk_y, rsp_valid, rsp_flags, busy, grant_id
    );

    modport slave (
        input  req, req_x, req_y, lk_flags,
        output lk_valid, lk_x, lk_y, rsp_valid, rsp_flags, busy, grant_id
    );
endinterface

// File: rtl/maze_query_arbiter.sv
// Round-robin arbiter sharing one maze-lookup unit among four requesters.
// A grant runs IDLE -> ISSUE (1 cycle, lk_valid) -> WAIT (LOOKUP_LAT
// cycles) -> RESP (1 cycle, one-hot rsp_valid), so one grant occupies
// LOOKUP_LAT+3 cycles and coordinates are captured once at the grant.
//
// Ports:
//   clk_50mhz : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : maze_query_arbiter_if.slave (request, lookup, response)
// Parameters:
//   LOOKUP_LAT: cycles from lk_valid to valid lk_flags, legal 1..7
// Build option:
//   MAZE_ARB_PAC_PRIORITY_EN : when defined, pacman (req[0]) always wins
//   when set; the monsters round-robin among themselves otherwise.
module maze_query_arbiter #(
    parameter int LOOKUP_LAT = 2
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_n,
    maze_query_arbiter_if.slave  bus
);
    localparam int NUM_REQ = 4;
    localparam int COORD_W = 9;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                            state, state_nxt;
    logic [2:0]                        wait_cnt;
    logic [1:0]                        last_grant;
    logic [1:0]                        grant_id;
    logic [COORD_W-1:0]                lk_x, lk_y;
    logic [3:0]                        rsp_flags;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [NUM_REQ-1:0][COORD_W-1:0]   req_x_v, req_y_v;
    logic [NUM_REQ-1:0]                cand;
    logic                              win_vld;
    logic [1:0]                        win_id;
    logic [1:0]                        idx;

    assign req_x_v = bus.req_x;
    assign req_y_v = bus.req_y;

    // Candidate set for arbitration. With pacman priority the round-robin
    // pointer still advances on every grant, so monsters keep fair order
    // among themselves whenever pacman is quiet.
    always_comb begin
`ifdef MAZE_ARB_PAC_PRIORITY_EN
        cand = bus.req[0] ? 4'b0001 : (bus.req & 4'b1110);
`else
        cand = bus.req;
`endif
    end

    // Search from last_grant+1 upward with 2-bit wraparound; k=4 lands back
    // on last_grant so a lone repeat requester still gets served.
    always_comb begin
        win_vld = 1'b0;
        win_id  = last_grant;
        idx     = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_grant + 2'(k);
            if (!win_vld && cand[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath. lk_x/lk_y/grant_id are written only on the IDLE->ISSUE edge,
    // which keeps them stable through RESP regardless of requester activity.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            lk_x       <= '0;
            lk_y       <= '0;
            grant_id   <= 2'd0;
            last_grant <= 2'd3;   // requester 0 wins first after reset
            wait_cnt   <= 3'd0;
            rsp_flags  <= 4'd0;
        end else begin
            unique case (state)
                IDLE: if (win_vld) begin
                    lk_x     <= req_x_v[win_id];
                    lk_y     <= req_y_v[win_id];
                    grant_id <= win_id;
                end
                ISSUE: wait_cnt <= 3'(LOOKUP_LAT - 1);
                WAIT: begin
                    // counter hits zero in the last WAIT cycle, exactly when
                    // the lookup unit presents its result
                    if (wait_cnt == 3'd0) rsp_flags <= bus.lk_flags;
                    else                  wait_cnt  <= wait_cnt - 3'd1;
                end
                RESP: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int g = 0; g < NUM_REQ; g++)
            rsp_valid[g] = (state == RESP) && (grant_id == 2'(g));
    end

    assign bus.lk_valid  = (state == ISSUE);
    assign bus.busy      = (state != IDLE);
    assign bus.lk_x      = lk_x;
    assign bus.lk_y      = lk_y;
    assign bus.grant_id  = grant_id;
    assign bus.rsp_flags = rsp_flags;
    assign bus.rsp_valid = rsp_valid;
endmodule

// File: tb/tb_maze_query_arbiter.sv
// Directed bench for maze_query_arbiter (LOOKUP_LAT=2). A vector table
// drives back-to-back grants; hand-written sequences cover reset state,
// idle behaviour and reset during WAIT. Expectations that depend on the
// pacman-priority build are selected with the same macro.
module tb_maze_query_arbiter;
    localparam int LAT = 2;

    logic clk_50mhz = 1'b0;
    logic rst_n     = 1'b0;
    int   cyc       = 0;
    int   nvec      = 0;
    int   nfail     = 0;
    int   last_rsp  = 0;

    always #10 clk_50mhz = ~clk_50mhz;
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    maze_query_arbiter_if bus();

    maze_query_arbiter #(.LOOKUP_LAT(LAT)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    // Lookup unit model: result appears LAT cycles after lk_valid, junk
    // (4'b1111) otherwise so an early or late sample shows up.
    logic [7:0] vp = '0;
    always @(posedge clk_50mhz) vp <= {vp[6:0], bus.lk_valid};

    function automatic logic [3:0] lkf(input logic [8:0] x, input logic [8:0] y);
        if (x == 9'd20 && y == 9'd200) return 4'b1010;
        return x[3:0] ^ y[3:0];
    endfunction

    assign bus.lk_flags = vp[LAT-1] ? lkf(bus.lk_x, bus.lk_y) : 4'b1111;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  req_mid;
        logic [35:0] rx;
        logic [35:0] ry;
        logic [1:0]  gid;
        logic [8:0]  lx;
        logic [8:0]  ly;
        logic [3:0]  flags;
        logic        gap;
    } vec_t;

    vec_t vt[13];

    function automatic logic [35:0] c4(input int a3, input int a2, input int a1, input int a0);
        return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] rm,
                                input logic [35:0] rx, input logic [35:0] ry,
                                input logic [1:0] g, input int lx, input int ly,
                                input logic [3:0] fl, input logic gp);
        vec_t v;
        v.req = rq; v.req_mid = rm; v.rx = rx; v.ry = ry; v.gid = g;
        v.lx = 9'(lx); v.ly = 9'(ly); v.flags = fl; v.gap = gp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered at #1 after an edge where the DUT is (or becomes) IDLE;
    // returns at #1 after the edge that ends RESP.
    task automatic run_vec(input int i);
        vec_t v;
        int n;
        logic [3:0] exp_rv;
        v = vt[i];
        exp_rv = 4'b0001 << v.gid;
        bus.req = v.req; bus.req_x = v.rx; bus.req_y = v.ry;
        n = 0;
        while (n < 20) begin
            @(negedge clk_50mhz); n++;
            if (bus.lk_valid) break;
        end
        chk($sformatf("v%0d lk_valid latency", i), 32'(n), 32'd2);
        chk($sformatf("v%0d grant_id", i), 32'(bus.grant_id), 32'(v.gid));
        chk($sformatf("v%0d lk_x", i), 32'(bus.lk_x), 32'(v.lx));
        chk($sformatf("v%0d lk_y", i), 32'(bus.lk_y), 32'(v.ly));
        // after the grant: scramble coordinates, apply mid-transaction req
        bus.req = v.req_mid; bus.req_x = ~v.rx; bus.req_y = ~v.ry;
        n = 0;
        while (n < 20) begin
            @(negedge clk_50mhz); n++;
            if (bus.rsp_valid != 4'd0) break;
        end
        chk($sformatf("v%0d rsp latency", i), 32'(n), 32'(LAT + 1));
        chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(exp_rv));
        chk($sformatf("v%0d rsp_flags", i), 32'(bus.rsp_flags), 32'(v.flags));
        chk($sformatf("v%0d lk_x hold", i), 32'(bus.lk_x), 32'(v.lx));
        chk($sformatf("v%0d grant hold", i), 32'(bus.grant_id), 32'(v.gid));
        chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'd1);
        if (v.gap) chk($sformatf("v%0d rsp spacing", i), 32'(cyc - last_rsp), 32'(LAT + 3));
        last_rsp = cyc;
        @(posedge clk_50mhz); #1;
        bus.req = 4'd0;
    endtask

    initial begin
        int  n;
        logic seen;
        // 0x: 180/180 for requester 1, 5/3 for requester 2
        vt[0]  = mk(4'b0110, 4'b0110, c4(0, 5, 180, 0), c4(0, 3, 180, 0), 2'd1, 180, 180, 4'b0000, 1'b0);
        vt[1]  = mk(4'b0100, 4'b0100, c4(0, 5, 180, 0), c4(0, 3, 180, 0), 2'd2,   5,   3, 4'b0110, 1'b1);
        vt[2]  = mk(4'b0001, 4'b0001, c4(0, 0, 0, 20),  c4(0, 0, 0, 200), 2'd0,  20, 200, 4'b1010, 1'b1);
        vt[3]  = mk(4'b1000, 4'b0000, c4(9, 0, 0, 0),   c4(12, 0, 0, 0),  2'd3,   9,  12, 4'b0101, 1'b1);
        vt[4]  = mk(4'b1111, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd0,   4,   1, 4'b0101, 1'b1);
        vt[5]  = mk(4'b1110, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd1,   5,   1, 4'b0100, 1'b1);
`ifdef MAZE_ARB_PAC_PRIORITY_EN
        vt[6]  = mk(4'b1101, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd0,   4,   1, 4'b0101, 1'b1);
        vt[7]  = mk(4'b1011, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd0,   4,   1, 4'b0101, 1'b1);
        vt[8]  = mk(4'b0111, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd0,   4,   1, 4'b0101, 1'b1);
        for (int k = 9; k < 13; k++)
            vt[k] = mk(4'b1001, 4'b1001, c4(2, 0, 0, 8), c4(1, 0, 0, 1),  2'd0,   8,   1, 4'b1001, 1'b1);
`else
        vt[6]  = mk(4'b1101, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd2,   6,   1, 4'b0111, 1'b1);
        vt[7]  = mk(4'b1011, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd3,   7,   1, 4'b0110, 1'b1);
        vt[8]  = mk(4'b0111, 4'b1111, c4(7, 6, 5, 4),   c4(1, 1, 1, 1),   2'd0,   4,   1, 4'b0101, 1'b1);
        for (int k = 9; k < 13; k++) begin
            if (k % 2 == 1) vt[k] = mk(4'b1001, 4'b1001, c4(2, 0, 0, 8), c4(1, 0, 0, 1), 2'd3, 2, 1, 4'b0011, 1'b1);
            else            vt[k] = mk(4'b1001, 4'b1001, c4(2, 0, 0, 8), c4(1, 0, 0, 1), 2'd0, 8, 1, 4'b1001, 1'b1);
        end
`endif

        bus.req = 4'd0; bus.req_x = '0; bus.req_y = '0;
        repeat (3) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk("reset lk_valid", 32'(bus.lk_valid), 32'd0);
        chk("reset lk_x", 32'(bus.lk_x), 32'd0);
        chk("reset lk_y", 32'(bus.lk_y), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset grant_id", 32'(bus.grant_id), 32'd0);
        @(posedge clk_50mhz); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50mhz);
            chk("idle busy", 32'(bus.busy), 32'd0);
            chk("idle lk_valid", 32'(bus.lk_valid), 32'd0);
        end
        @(posedge clk_50mhz); #1;

        for (int i = 0; i < 13; i++) run_vec(i);

        // reset during WAIT: transaction for requester 2 is dropped
        bus.req = 4'b0100; bus.req_x = c4(0, 33, 0, 0); bus.req_y = c4(0, 1, 0, 0);
        n = 0;
        while (n < 20) begin
            @(negedge clk_50mhz); n++;
            if (bus.lk_valid) break;
        end
        chk("abort lk_valid latency", 32'(n), 32'd2);
        chk("abort grant_id", 32'(bus.grant_id), 32'd2);
        @(negedge clk_50mhz);                 // first WAIT cycle
        @(posedge clk_50mhz); #1;
        rst_n = 1'b0;
        bus.req = 4'b0101; bus.req_x = c4(0, 33, 0, 3); bus.req_y = c4(0, 1, 0, 10);
        @(posedge clk_50mhz); #1;
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        seen = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk_50mhz); n++;
            if (bus.rsp_valid != 4'd0) seen = 1'b1;
            if (bus.lk_valid) break;
        end
        chk("abort no rsp", 32'(seen), 32'd0);
        chk("post-reset lk_valid latency", 32'(n), 32'd1);
        chk("post-reset grant_id", 32'(bus.grant_id), 32'd0);
        chk("post-reset lk_x", 32'(bus.lk_x), 32'd3);
        n = 0;
        while (n < 20) begin
            @(negedge clk_50mhz); n++;
            if (bus.rsp_valid != 4'd0) break;
        end
        chk("post-reset rsp latency", 32'(n), 32'(LAT + 1));
        chk("post-reset rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("post-reset rsp_flags", 32'(bus.rsp_flags), 32'b1001);
        @(posedge clk_50mhz); #1;
        bus.req = 4'd0;
        @(negedge clk_50mhz);
        chk("rsp_flags retained", 32'(bus.rsp_flags), 32'b1001);
        chk("rsp_valid cleared", 32'(bus.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
